// File: rtl/pll_reconfig_supervisor.sv
// rtl/pll_reconfig_supervisor.sv - rPLL divider select, reset sequencing and lock supervision (optional PLL_RETRY_LIMIT_EN)
`timescale 1ns/1ps
module pll_reconfig_supervisor #(
    parameter int         M0_IDIV       = 3,
    parameter int         M0_FBDIV      = 54,
    parameter logic [5:0] M0_ODSEL      = 6'b111000,
    parameter int         M1_IDIV       = 2,
    parameter int         M1_FBDIV      = 13,
    parameter logic [5:0] M1_ODSEL      = 6'b111000,
    parameter int         CNT_W         = 20,
    parameter int         RST_CYCLES    = 32,
    parameter int         LOCK_TIMEOUT  = 540000,
    parameter int         STABLE_CYCLES = 27000,
    parameter int         MAX_RETRY     = 3
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       mode_i,
    input  logic       pll_lock_i,
    output logic       pll_reset_o,
    output logic [5:0] idsel_o,
    output logic [5:0] fbdsel_o,
    output logic [5:0] odsel_o,
    output logic       sys_resetn_o,
    output logic       mode_o,
    output logic       locked_o,
    output logic [1:0] retry_o,
    output logic       fault_o
);

    typedef enum logic [2:0] {
        S_RST_PLL   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

`ifdef PLL_RETRY_LIMIT_EN
    localparam bit RETRY_LIMIT_EN = 1'b1;
`else
    localparam bit RETRY_LIMIT_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    // The WAIT_LOCK cycle that first saw lock counts as stable cycle one.
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 2);

    localparam logic [5:0] M0_IDSEL  = ~6'(M0_IDIV);
    localparam logic [5:0] M0_FBDSEL = ~6'(M0_FBDIV);
    localparam logic [5:0] M1_IDSEL  = ~6'(M1_IDIV);
    localparam logic [5:0] M1_FBDSEL = ~6'(M1_FBDIV);

    logic             lock_meta;
    logic             lock_s;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] timer_q;
    logic [CNT_W-1:0] timer_d;
    logic [1:0]       retry_q;
    logic [1:0]       retry_d;
    logic [1:0]       retry_inc;
    logic             mode_q;
    logic             mode_change;
    logic             enter_rst;
    logic             sys_resetn_q;
    logic [5:0]       idsel_q;
    logic [5:0]       fbdsel_q;
    logic [5:0]       odsel_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock_i;
            lock_s    <= lock_meta;
        end
    end

    assign mode_change = (mode_i != mode_q);
    assign retry_inc   = (retry_q == 2'd3) ? 2'd3 : retry_q + 2'd1;
    assign enter_rst   = (state_d == S_RST_PLL) && (state_q != S_RST_PLL);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + CNT_W'(1);
        retry_d = retry_q;
        case (state_q)
            S_RST_PLL: begin
                if (timer_q >= RST_LAST) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (mode_change) begin
                    state_d = S_RST_PLL;
                end else if (lock_s) begin
                    state_d = S_STABLE;
                end else if (timer_q >= LOCK_LAST) begin
                    retry_d = retry_inc;
                    if (RETRY_LIMIT_EN && (int'(retry_inc) >= MAX_RETRY)) state_d = S_FAULT;
                    else state_d = S_RST_PLL;
                end
            end
            S_STABLE: begin
                if (mode_change) begin
                    state_d = S_RST_PLL;
                end else if (!lock_s) begin
                    state_d = S_WAIT_LOCK;
                end else if (timer_q >= STABLE_LAST) begin
                    state_d = S_RUN;
                    retry_d = 2'd0;
                end
            end
            S_RUN: begin
                timer_d = timer_q;
                if (!lock_s || mode_change) state_d = S_RST_PLL;
            end
            S_FAULT: begin
                timer_d = timer_q;
            end
            default: begin
                state_d = S_RST_PLL;
            end
        endcase
        if (state_d != state_q) timer_d = '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_RST_PLL;
            timer_q      <= '0;
            retry_q      <= 2'd0;
            sys_resetn_q <= 1'b0;
            mode_q       <= 1'b0;
            idsel_q      <= M0_IDSEL;
            fbdsel_q     <= M0_FBDSEL;
            odsel_q      <= M0_ODSEL;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            retry_q      <= retry_d;
            // Drops on the same edge RUN is left, rises one cycle after RUN is entered.
            sys_resetn_q <= (state_q == S_RUN) && (state_d == S_RUN);
            if (enter_rst) begin
                mode_q   <= mode_i;
                idsel_q  <= mode_i ? M1_IDSEL  : M0_IDSEL;
                fbdsel_q <= mode_i ? M1_FBDSEL : M0_FBDSEL;
                odsel_q  <= mode_i ? M1_ODSEL  : M0_ODSEL;
            end
        end
    end

    assign pll_reset_o  = (state_q == S_RST_PLL) || (state_q == S_FAULT);
    assign locked_o     = (state_q == S_RUN);
    assign sys_resetn_o = sys_resetn_q;
    assign mode_o       = mode_q;
    assign retry_o      = retry_q;
    assign idsel_o      = idsel_q;
    assign fbdsel_o     = fbdsel_q;
    assign odsel_o      = odsel_q;

`ifdef PLL_RETRY_LIMIT_EN
    assign fault_o = (state_q == S_FAULT);
`else
    assign fault_o = 1'b0;
`endif

endmodule

// File: tb/tb_pll_reconfig_supervisor.sv
// tb/tb_pll_reconfig_supervisor.sv - table-driven and randomized checks of pll_reconfig_supervisor
`timescale 1ns/1ps
module tb_pll_reconfig_supervisor;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 16;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRY     = 3;
`ifdef PLL_RETRY_LIMIT_EN
    localparam bit LIMIT = 1'b1;
`else
    localparam bit LIMIT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetn;
    logic       mode_i;
    logic       pll_lock_i;
    logic       pll_reset_o;
    logic [5:0] idsel_o;
    logic [5:0] fbdsel_o;
    logic [5:0] odsel_o;
    logic       sys_resetn_o;
    logic       mode_o;
    logic       locked_o;
    logic [1:0] retry_o;
    logic       fault_o;

    always #5 clk = ~clk;

    pll_reconfig_supervisor #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .STABLE_CYCLES(STABLE_CYCLES),
        .MAX_RETRY    (MAX_RETRY)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .mode_i      (mode_i),
        .pll_lock_i  (pll_lock_i),
        .pll_reset_o (pll_reset_o),
        .idsel_o     (idsel_o),
        .fbdsel_o    (fbdsel_o),
        .odsel_o     (odsel_o),
        .sys_resetn_o(sys_resetn_o),
        .mode_o      (mode_o),
        .locked_o    (locked_o),
        .retry_o     (retry_o),
        .fault_o     (fault_o)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: phase 0 reset pulse, 1 waiting, 2 qualifying, 3 running, 4 fault.
    int m_ph, m_age, m_hi, m_retry;
    bit m_mode, m_sys, m_s1, m_s2;

    function automatic void model_reset();
        m_ph = 0; m_age = 0; m_hi = 0; m_retry = 0;
        m_mode = 1'b0; m_sys = 1'b0; m_s1 = 1'b0; m_s2 = 1'b0;
    endfunction

    function automatic void model_step(input bit md, input bit lk);
        bit ls;
        bit mism;
        int nph;
        ls   = m_s2;
        mism = (md != m_mode);
        nph  = m_ph;
        if (ls && (m_ph == 1 || m_ph == 2)) m_hi = m_hi + 1;
        else m_hi = 0;
        case (m_ph)
            0: if (m_age + 1 >= RST_CYCLES) nph = 1;
            1: begin
                if (mism) nph = 0;
                else if (ls) nph = 2;
                else if (m_age + 1 >= LOCK_TIMEOUT) begin
                    m_retry = (m_retry < 3) ? m_retry + 1 : 3;
                    nph = (LIMIT && m_retry >= MAX_RETRY) ? 4 : 0;
                end
            end
            2: begin
                if (mism) nph = 0;
                else if (!ls) nph = 1;
                else if (m_hi >= STABLE_CYCLES) begin
                    nph = 3;
                    m_retry = 0;
                end
            end
            3: if (mism || !ls) nph = 0;
            default: ;
        endcase
        m_sys = (m_ph == 3) && (nph == 3);
        if (nph == 0 && m_ph != 0) m_mode = md;
        m_age = (nph != m_ph) ? 0 : m_age + 1;
        m_ph  = nph;
        m_s2  = m_s1;
        m_s1  = lk;
    endfunction

    function automatic logic [5:0] exp_id(input bit m);
        return 6'(63 - (m ? 2 : 3));
    endfunction

    function automatic logic [5:0] exp_fb(input bit m);
        return 6'(63 - (m ? 13 : 54));
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        cmp({tag, ".pll_reset"},  32'(pll_reset_o),  32'(m_ph == 0 || m_ph == 4));
        cmp({tag, ".sys_resetn"}, 32'(sys_resetn_o), 32'(m_sys));
        cmp({tag, ".locked"},     32'(locked_o),     32'(m_ph == 3));
        cmp({tag, ".mode"},       32'(mode_o),       32'(m_mode));
        cmp({tag, ".idsel"},      32'(idsel_o),      32'(exp_id(m_mode)));
        cmp({tag, ".fbdsel"},     32'(fbdsel_o),     32'(exp_fb(m_mode)));
        cmp({tag, ".odsel"},      32'(odsel_o),      32'(6'b111000));
        cmp({tag, ".retry"},      32'(retry_o),      32'(m_retry));
        cmp({tag, ".fault"},      32'(fault_o),      32'(m_ph == 4));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(mode_i, pll_lock_i);
        @(negedge clk);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    typedef struct {
        int         n;
        bit         md;
        bit         lk;
        bit         pr;
        bit         sr;
        bit         lkd;
        bit         mo;
        logic [5:0] id;
        logic [5:0] fb;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input int n, input bit md, input bit lk, input bit pr,
                                input bit sr, input bit lkd, input bit mo);
        vec_t v;
        v.n = n; v.md = md; v.lk = lk; v.pr = pr; v.sr = sr; v.lkd = lkd; v.mo = mo;
        v.id = mo ? 6'b111101 : 6'b111100;
        v.fb = mo ? 6'b110010 : 6'b001001;
        tbl.push_back(v);
    endfunction

    initial begin
        int seen;
        int edges;
        int last_rise;
        int rises;
        bit prev_pr;

        // Power-up, lock 3 cycles after PLL reset falls, then a mode switch in RUN.
        add(3, 0, 0, 1, 0, 0, 0);
        add(4, 0, 0, 0, 0, 0, 0);
        add(2, 0, 1, 0, 0, 0, 0);
        add(7, 0, 1, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 1, 0);
        add(2, 0, 1, 0, 1, 1, 0);
        add(4, 1, 1, 1, 0, 0, 1);
        add(8, 1, 1, 0, 0, 0, 1);
        add(1, 1, 1, 0, 0, 1, 1);
        add(2, 1, 1, 0, 1, 1, 1);

        resetn = 1'b0;
        mode_i = 1'b0;
        pll_lock_i = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        cmp("rst.pll_reset",  32'(pll_reset_o),  32'd1);
        cmp("rst.sys_resetn", 32'(sys_resetn_o), 32'd0);
        cmp("rst.locked",     32'(locked_o),     32'd0);
        cmp("rst.retry",      32'(retry_o),      32'd0);
        cmp("rst.fault",      32'(fault_o),      32'd0);
        cmp("rst.idsel",      32'(idsel_o),      32'h3c);
        cmp("rst.fbdsel",     32'(fbdsel_o),     32'h09);
        check_all("rst");
        resetn = 1'b1;

        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                mode_i = tbl[i].md;
                pll_lock_i = tbl[i].lk;
                tick();
                cmp($sformatf("tbl%0d.pll_reset", i), 32'(pll_reset_o),  32'(tbl[i].pr));
                cmp($sformatf("tbl%0d.sys_resetn", i), 32'(sys_resetn_o), 32'(tbl[i].sr));
                cmp($sformatf("tbl%0d.locked", i),     32'(locked_o),     32'(tbl[i].lkd));
                cmp($sformatf("tbl%0d.mode", i),       32'(mode_o),       32'(tbl[i].mo));
                cmp($sformatf("tbl%0d.idsel", i),      32'(idsel_o),      32'(tbl[i].id));
                cmp($sformatf("tbl%0d.fbdsel", i),     32'(fbdsel_o),     32'(tbl[i].fb));
                check_all("tblm");
            end
        end

        // Lock glitch while qualifying: back to waiting without a PLL reset.
        pll_lock_i = 1'b0;
        for (int k = 0; k < 50 && m_ph != 0; k++) begin tick(); check_all("glitch"); end
        pll_lock_i = 1'b1;
        for (int k = 0; k < 100 && !(m_ph == 2 && m_age == 2); k++) begin tick(); check_all("glitch"); end
        cmp("glitch.reach_stable", 32'(m_ph == 2 && m_age == 2), 32'd1);
        pll_lock_i = 1'b0;
        tick(); check_all("glitch");
        pll_lock_i = 1'b1;
        seen = 0;
        edges = 0;
        for (int k = 0; k < 60 && !sys_resetn_o; k++) begin
            tick(); check_all("glitch");
            edges++;
            if (pll_reset_o) seen++;
        end
        cmp("glitch.no_pll_reset", 32'(seen), 32'd0);
        cmp("glitch.relock_to_release", 32'(edges), 32'd11);

        // Asynchronous reset pulse while qualifying lock.
        mode_i = 1'b0;
        for (int k = 0; k < 100 && m_ph != 2; k++) begin tick(); check_all("areset"); end
        cmp("areset.reach_stable", 32'(m_ph), 32'd2);
        #2;
        resetn = 1'b0;
        #0.5;
        cmp("areset.pll_reset",  32'(pll_reset_o),  32'd1);
        cmp("areset.sys_resetn", 32'(sys_resetn_o), 32'd0);
        cmp("areset.locked",     32'(locked_o),     32'd0);
        cmp("areset.mode",       32'(mode_o),       32'd0);
        cmp("areset.idsel",      32'(idsel_o),      32'h3c);
        cmp("areset.retry",      32'(retry_o),      32'd0);
        #0.5;
        resetn = 1'b1;
        model_reset();
        for (int k = 0; k < 5; k++) begin tick(); check_all("areset"); end

        // Lock never arrives: repeated timeouts.
        @(negedge clk);
        mode_i = 1'b0;
        pll_lock_i = 1'b0;
        do_reset();
        last_rise = -1;
        rises = 0;
        prev_pr = 1'b1;
        seen = 0;
        for (int k = 0; k < 220; k++) begin
            tick(); check_all("timeout");
            if (pll_reset_o && !prev_pr) begin
                if (last_rise >= 0) cmp("timeout.period", 32'(k - last_rise), 32'd20);
                last_rise = k;
                rises++;
            end
            if (k >= 60 && !pll_reset_o) seen++;
            prev_pr = pll_reset_o;
        end
`ifdef PLL_RETRY_LIMIT_EN
        cmp("timeout.fault",       32'(fault_o),     32'd1);
        cmp("timeout.pll_held",    32'(seen),        32'd0);
        cmp("timeout.rises",       32'(rises),       32'd3);
`else
        cmp("timeout.retry_sat",   32'(retry_o),     32'd3);
        cmp("timeout.fault",       32'(fault_o),     32'd0);
        cmp("timeout.rises",       32'(rises >= 10), 32'd1);
`endif

        // Randomized lock and mode activity against the model.
        do_reset();
        for (int k = 0; k < 3000 && n_err < 20; k++) begin
            if (pll_lock_i) begin
                if ($urandom_range(39, 0) == 0) pll_lock_i = 1'b0;
            end else begin
                if ($urandom_range(11, 0) == 0) pll_lock_i = 1'b1;
            end
            if ($urandom_range(299, 0) == 0) mode_i = ~mode_i;
            if (m_ph == 4 && $urandom_range(19, 0) == 0) do_reset();
            tick();
            check_all("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
